// File: rtl/zxnet_bus_seq.sv
// rtl/zxnet_bus_seq.sv - shared W5300/SL811 chip bus sequencer with two-port arbitration
// All chip-facing outputs are registered from next-state values so they are glitch-free.
module zxnet_bus_seq #(
    parameter int SETUP_CYC = 1,
    parameter int W_STROBE  = 3,
    parameter int S_STROBE  = 4,
    parameter int HOLD_CYC  = 1,
    parameter int MAXWAIT   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic       sel0,
    input  logic       sel1,
    input  logic [9:0] addr0,
    input  logic [9:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       done0,
    output logic       done1,
    output logic       err,
    output logic [7:0] rdata,
    output logic       busy,
    input  logic       w5300_rst_n,
    input  logic       sl811_rst_n,
    output logic [9:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_oe,
    input  logic [7:0] bus_rdata,
    output logic       w5300_cs_n,
    output logic       sl811_cs_n,
    output logic       rd_n,
    output logic       wr_n
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam logic [3:0] SETUP_INIT = 4'(SETUP_CYC - 1);
    localparam logic [3:0] W_INIT     = 4'(W_STROBE - 1);
    localparam logic [3:0] S_INIT     = 4'(S_STROBE - 1);
    localparam logic [3:0] HOLD_INIT  = 4'(HOLD_CYC - 1);
    localparam logic [2:0] SKIP_MAX   = 3'(MAXWAIT);

    state_t     state, nx_state;
    logic [3:0] cnt, nx_cnt;
    logic [2:0] skip, nx_skip;
    logic       we_r, sel_r, port_r, err_r;
    logic       nx_we, nx_sel, nx_port, nx_err;
    logic [9:0] nx_addr;
    logic [7:0] nx_wdata, nx_rdata;
    logic       grant1, tgt_ok, active;

    // Port 1 wins only when port 0 is idle or has starved it for MAXWAIT grants.
    assign grant1 = req1 && (!req0 || (skip == SKIP_MAX));

    always_comb begin
        nx_state = state;
        nx_cnt   = cnt;
        nx_skip  = skip;
        nx_we    = we_r;
        nx_sel   = sel_r;
        nx_port  = port_r;
        nx_err   = err_r;
        nx_addr  = bus_addr;
        nx_wdata = bus_wdata;
        nx_rdata = rdata;
        tgt_ok   = 1'b1;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    nx_port  = grant1;
                    nx_we    = grant1 ? we1 : we0;
                    nx_sel   = grant1 ? sel1 : sel0;
                    nx_addr  = grant1 ? addr1 : addr0;
                    nx_wdata = grant1 ? wdata1 : wdata0;
                    if (grant1)
                        nx_skip = 3'd0;
                    else if (req1 && skip != SKIP_MAX)
                        nx_skip = skip + 3'd1;
                    tgt_ok = nx_sel ? sl811_rst_n : w5300_rst_n;
                    if (!tgt_ok) begin
                        nx_state = DONE;
                        nx_err   = 1'b1;
                        if (!nx_we)
                            nx_rdata = 8'hFF;
                    end else begin
                        nx_state = SETUP;
                        nx_err   = 1'b0;
                        nx_cnt   = SETUP_INIT;
                    end
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    nx_state = STROBE;
                    nx_cnt   = sel_r ? S_INIT : W_INIT;
                end else begin
                    nx_cnt = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    if (!we_r)
                        nx_rdata = bus_rdata;
                    nx_state = HOLD;
                    nx_cnt   = HOLD_INIT;
                end else begin
                    nx_cnt = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0)
                    nx_state = DONE;
                else
                    nx_cnt = cnt - 4'd1;
            end
            DONE:    nx_state = IDLE;
            default: nx_state = IDLE;
        endcase
        active = (nx_state == SETUP) || (nx_state == STROBE) || (nx_state == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            skip       <= 3'd0;
            we_r       <= 1'b0;
            sel_r      <= 1'b0;
            port_r     <= 1'b0;
            err_r      <= 1'b0;
            bus_addr   <= 10'd0;
            bus_wdata  <= 8'd0;
            rdata      <= 8'h00;
            w5300_cs_n <= 1'b1;
            sl811_cs_n <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            bus_oe     <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nx_state;
            cnt        <= nx_cnt;
            skip       <= nx_skip;
            we_r       <= nx_we;
            sel_r      <= nx_sel;
            port_r     <= nx_port;
            err_r      <= nx_err;
            bus_addr   <= nx_addr;
            bus_wdata  <= nx_wdata;
            rdata      <= nx_rdata;
            w5300_cs_n <= !(active && !nx_sel);
            sl811_cs_n <= !(active && nx_sel);
            rd_n       <= !((nx_state == STROBE) && !nx_we);
            wr_n       <= !((nx_state == STROBE) && nx_we);
            bus_oe     <= active && nx_we;
            done0      <= (nx_state == DONE) && !nx_port;
            done1      <= (nx_state == DONE) && nx_port;
            err        <= (nx_state == DONE) && nx_err;
            busy       <= (nx_state != IDLE);
        end
    end

endmodule

// File: doc/zxnet_bus_seq.md
Name: zxnet_bus_seq

Overview:
- Sequences every access to the card's shared chip bus, which serves the W5300 ethernet controller and the SL811 USB host.
- Arbitrates between two requesters: port 0 is ZX host accesses, port 1 is the internal interrupt and status poller.
- Generates chip-select, read and write strobes with parameterised setup, strobe and hold timing.
- Sits between the ZX-bus decode/port logic and the chip pins; the chip reset lines from the control-port block gate its accesses.

Parameters:
SETUP_CYC, 1, cycles with CS low before the strobe (legal range 1..15)
W_STROBE, 3, rd_n/wr_n low width in cycles for W5300 (1..15)
S_STROBE, 4, rd_n/wr_n low width in cycles for SL811 (1..15)
HOLD_CYC, 1, cycles with CS held low after the strobe (1..15)
MAXWAIT, 3, number of consecutive port-0 grants while req1 is pending before port 1 is forced (1..7)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous reset, active-high
req0/req1  in  1  access request; fields held stable until that port's done
we0/we1  in  1  1=write, 0=read
sel0/sel1  in  1  target: 0=W5300, 1=SL811
addr0/addr1  in  10  chip address
wdata0/wdata1  in  8  write data
done0/done1  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done: target was held in reset
rdata  out  8  read result, valid from the done cycle onward
busy  out  1  state != IDLE
w5300_rst_n, sl811_rst_n  in  1  chip reset levels from the control-port block
bus_addr  out  10  registered chip address
bus_wdata  out  8  registered write data
bus_oe  out  1  drive bus_wdata onto the chip data bus
bus_rdata  in  8  chip data bus input
w5300_cs_n, sl811_cs_n, rd_n, wr_n  out  1  chip strobes, active-low, registered

Behaviour:
- Reset (async, rst=1) forces:
  - state IDLE;
  - all cs_n, rd_n, wr_n = 1;
  - bus_oe = 0;
  - done0, done1, err, busy = 0;
  - rdata = 8'h00, bus_addr = 0, bus_wdata = 0;
  - skip counter = 0.
- Reset mid-access aborts immediately with the same values; no done pulse is issued for the aborted access.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE. A 4-bit down-counter times SETUP, STROBE and HOLD.
- IDLE:
  - Arbitrate only when req0 or req1 is high.
  - Winner's we, sel, addr and wdata are latched into bus_addr, bus_wdata and internal regs.
  - If the target's rst_n is low: go to DONE with err=1 and rdata=8'hFF (reads only). No strobes toggle.
  - Otherwise go to SETUP with counter=SETUP_CYC-1.
- SETUP: selected cs_n=0; rd_n=wr_n=1; bus_oe=we. When the counter reaches 0, go to STROBE with counter=(sel ? S_STROBE : W_STROBE)-1.
- STROBE: cs_n=0; rd_n=~(~we), i.e. low for reads; wr_n=~we, i.e. low for writes. On the clock edge that ends the last STROBE cycle of a read, rdata<=bus_rdata. Then go to HOLD with counter=HOLD_CYC-1.
- HOLD: cs_n=0, strobes high, bus_oe held. When the counter reaches 0, go to DONE.
- DONE:
  - All cs_n high, bus_oe=0.
  - done of the granted port = 1 for exactly this cycle; err as latched.
  - No arbitration in DONE, so a req still high is not re-granted before the requester can drop it.
  - Next state IDLE.
- Latency: request sampled in IDLE at cycle 0 gives done in cycle 1+SETUP_CYC+T+HOLD_CYC (T = strobe width of the target).
  - Defaults: W5300 = 6, SL811 = 7, target in reset = 1.
  - Back-to-back throughput: one access per latency+1 cycles.
- Arbitration:
  - Port 0 has priority.
  - Skip counter increments on each port-0 grant while req1 is high, saturating at MAXWAIT, and clears on any port-1 grant.
  - When both request and skip==MAXWAIT, port 1 is granted.
- rdata holds its value until the next read completes; writes and err-free writes leave it unchanged.
- A chip rst_n going low mid-access does not abort; the cycle completes with normal timing and err=0.
- Strobe outputs come straight from registers and must be glitch-free; rd_n and wr_n are never low simultaneously.
- req/fields changing while not granted are ignored until sampled in IDLE.

Test Plan:
1. Reset, both chip rst_n=1, req0 write sel=0 addr=10'h155 wdata=8'hA5 -> w5300_cs_n low cycles 1-5, wr_n low cycles 2-4, bus_oe high 1-5, done0 at cycle 6, err=0.
2. req1 read sel=1, bench drives bus_rdata=8'h3C during strobe -> sl811_cs_n low 1-6, rd_n low 2-5, done1 at cycle 7, rdata=8'h3C.
3. sl811_rst_n=0, req0 read sel=1 -> no strobe activity, done0 and err at cycle 1, rdata=8'hFF.
4. req0 and req1 held continuously high -> grant sequence 0,0,0,1,0,0,0,1; no port granted twice within one DONE cycle.
5. Assert rst during a W5300 STROBE -> all strobes high and bus_oe=0 asynchronously, no done pulse; after release, a new req0 completes normally in 6 cycles.
6. Drop w5300_rst_n mid-read -> access completes at cycle 6 with err=0 and rdata=the bus_rdata value.
